hazard_ctrl_rv32: RTL and testbench

Parametrised pipeline hazard controller for the five-stage RV32I core, successor to the purely combinational hazard unit. It sits beside the pipeline registers and drives forwarding selects, per-stage enables and flushes. Beyond forwarding, load-use stalls and branch flushes, it adds:
- a post-reset pipeline flush,
- a memory-wait timeout with a sticky error,
- saturating stall and flush performance counters.

---
 rtl/hazard_ctrl_rv32_pkg.sv | 36 +++
 rtl/hazard_ctrl_rv32_sat_counter.sv | 27 ++
 rtl/hazard_ctrl_rv32.sv | 175 +++++++++++++++++
 tb/tb_hazard_ctrl_rv32.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_rv32_pkg.sv
//==========================================================================
// hazard_pkg - shared types for the RV32I hazard controller (rev 1.0)
//==========================================================================
`default_nettype none

package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_ERROR = 2'd2;

    typedef enum logic [1:0] {
        INIT  = ST_INIT,
        RUN   = ST_RUN,
        ERROR = ST_ERROR
    } hz_state_t;

    // Memory-stage result is newer than writeback, so it wins.
    function automatic fwd_sel_t fwd_pick(input logic hit_mem, input logic hit_wb);
        if (hit_mem)
            return FWD_MEM;
        else if (hit_wb)
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_ctrl_rv32_sat_counter.sv
//==========================================================================
// sat_counter - clearable up-counter that saturates at all-ones (rev 1.0)
//==========================================================================
`default_nettype none

module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + W'(1);
    end

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl_rv32.sv
//==========================================================================
// hazard_ctrl_rv32 - forwarding, stall/flush and timeout control (rev 1.0)
//==========================================================================
`default_nettype none

module hazard_ctrl_rv32
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W         = 6,
    parameter int ZERO_REG_HARDWIRED = 1,
    parameter int MEM_TIMEOUT        = 255,
    parameter int CNT_W              = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] r1_D,
    input  logic [REG_ADDR_W-1:0] r2_D,
    input  logic [REG_ADDR_W-1:0] r1_E,
    input  logic [REG_ADDR_W-1:0] r2_E,
    input  logic [REG_ADDR_W-1:0] rd_E,
    input  logic [REG_ADDR_W-1:0] rd_M,
    input  logic [REG_ADDR_W-1:0] rd_W,
    input  logic                  reg_write_M,
    input  logic                  reg_write_W,
    input  logic                  mem_to_reg_E,
    input  logic                  PC_source_E,
    input  logic                  mem_transaction,
    input  logic                  data_ready,
    input  logic                  instruction_ready,
    input  logic                  clear_error,
    input  logic                  perf_clear,
    output logic [1:0]            forward_operand_0_E,
    output logic [1:0]            forward_operand_1_E,
    output logic                  enable_fetch,
    output logic                  enable_decode,
    output logic                  enable_execute,
    output logic                  enable_memory,
    output logic                  enable_writeback,
    output logic                  flush_decode,
    output logic                  flush_execute,
    output logic                  flush_memory,
    output logic                  mem_timeout_error,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);

    localparam bit ZERO_HW = (ZERO_REG_HARDWIRED != 0);

    hz_state_t state;
    hz_state_t state_next;

    logic mem_stall;
    logic load_use;
    logic fwd_m_ok;
    logic fwd_w_ok;
    logic timeout_hit;
    logic timeout_inc;
    logic branch_flush;

    assign mem_stall = mem_transaction & ~data_ready;
    assign load_use  = mem_to_reg_E & ~(ZERO_HW && (rd_E == '0))
                     & ((rd_E == r1_D) | (rd_E == r2_D));

    assign fwd_m_ok = reg_write_M & ~(ZERO_HW && (rd_M == '0));
    assign fwd_w_ok = reg_write_W & ~(ZERO_HW && (rd_W == '0));

    assign forward_operand_0_E = fwd_pick(fwd_m_ok & (rd_M == r1_E), fwd_w_ok & (rd_W == r1_E));
    assign forward_operand_1_E = fwd_pick(fwd_m_ok & (rd_M == r2_E), fwd_w_ok & (rd_W == r2_E));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= INIT;
        else
            state <= state_next;
    end

    always_comb begin
        state_next       = state;
        enable_fetch     = 1'b0;
        enable_decode    = 1'b0;
        enable_execute   = 1'b0;
        enable_memory    = 1'b0;
        enable_writeback = 1'b0;
        flush_decode     = 1'b0;
        flush_execute    = 1'b0;
        flush_memory     = 1'b0;
        branch_flush     = 1'b0;
        case (state)
            INIT: begin
                flush_decode  = 1'b1;
                flush_execute = 1'b1;
                flush_memory  = 1'b1;
                state_next    = RUN;
            end
            RUN: begin
                // A pending memory stall freezes everything, even a taken branch.
                if (mem_stall) begin
                    if (timeout_hit)
                        state_next = ERROR;
                end else begin
                    enable_fetch     = 1'b1;
                    enable_decode    = 1'b1;
                    enable_execute   = 1'b1;
                    enable_memory    = 1'b1;
                    enable_writeback = 1'b1;
                    if (PC_source_E) begin
                        flush_decode  = 1'b1;
                        flush_execute = 1'b1;
                        branch_flush  = 1'b1;
                    end else if (load_use) begin
                        enable_fetch  = 1'b0;
                        enable_decode = 1'b0;
                        flush_execute = 1'b1;
                    end else if (!instruction_ready) begin
                        enable_fetch = 1'b0;
                        flush_decode = 1'b1;
                    end
                end
            end
            ERROR: begin
                flush_memory = 1'b1;
                if (clear_error)
                    state_next = INIT;
            end
            default: begin
                flush_decode  = 1'b1;
                flush_execute = 1'b1;
                flush_memory  = 1'b1;
                state_next    = INIT;
            end
        endcase
    end

    assign mem_timeout_error = (state == ERROR);
    assign timeout_inc       = (state == RUN) & mem_stall;

    generate
        if (MEM_TIMEOUT > 0) begin : g_timeout
            localparam int TO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
            logic [TO_W-1:0] to_count;

            sat_counter #(.W(TO_W)) u_timeout_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .inc   (timeout_inc),
                .clr   (~timeout_inc),
                .count (to_count)
            );

            // The stall cycle that would make the count reach the limit trips the error.
            assign timeout_hit = (to_count == TO_W'(MEM_TIMEOUT - 1));
        end else begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end
    endgenerate

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   ((state == RUN) & ~enable_fetch),
        .clr   (perf_clear),
        .count (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (branch_flush),
        .clr   (perf_clear),
        .count (flush_count)
    );

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl_rv32.sv
//==========================================================================
// tb_hazard_ctrl_rv32 - directed self-checking bench for hazard_ctrl_rv32
//==========================================================================
`default_nettype none

module tb_hazard_ctrl_rv32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] r1_D, r2_D, r1_E, r2_E, rd_E, rd_M, rd_W;
    logic       reg_write_M, reg_write_W, mem_to_reg_E, PC_source_E;
    logic       mem_transaction, data_ready, instruction_ready;
    logic       clear_error, perf_clear;
    logic [1:0] fwd0, fwd1;
    logic       en_f, en_d, en_e, en_m, en_w;
    logic       fl_d, fl_e, fl_m, err;
    logic [2:0] stall_count, flush_count;
    logic [4:0] en;
    logic [2:0] fl;
    int errors = 0;
    int checks = 0;

    assign en = {en_f, en_d, en_e, en_m, en_w};
    assign fl = {fl_d, fl_e, fl_m};

    always #5 clk = ~clk;

    hazard_ctrl_rv32 #(
        .REG_ADDR_W(6), .ZERO_REG_HARDWIRED(1), .MEM_TIMEOUT(4), .CNT_W(3)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .r1_D(r1_D), .r2_D(r2_D), .r1_E(r1_E), .r2_E(r2_E), .rd_E(rd_E),
        .rd_M(rd_M), .rd_W(rd_W), .reg_write_M(reg_write_M), .reg_write_W(reg_write_W),
        .mem_to_reg_E(mem_to_reg_E), .PC_source_E(PC_source_E),
        .mem_transaction(mem_transaction), .data_ready(data_ready),
        .instruction_ready(instruction_ready), .clear_error(clear_error),
        .perf_clear(perf_clear),
        .forward_operand_0_E(fwd0), .forward_operand_1_E(fwd1),
        .enable_fetch(en_f), .enable_decode(en_d), .enable_execute(en_e),
        .enable_memory(en_m), .enable_writeback(en_w),
        .flush_decode(fl_d), .flush_execute(fl_e), .flush_memory(fl_m),
        .mem_timeout_error(err), .stall_count(stall_count), .flush_count(flush_count)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        {r1_D, r2_D, r1_E, r2_E, rd_E, rd_M, rd_W} = '0;
        {reg_write_M, reg_write_W, mem_to_reg_E, PC_source_E} = '0;
        {mem_transaction, data_ready, clear_error, perf_clear} = '0;
        instruction_ready = 1'b1;
    endtask

    task automatic clear_perf();
        perf_clear = 1'b1;
        next_cycle();
        perf_clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        #2;
        checks++; if ({en, fl} !== 8'b00000_111) begin errors++; $display("FAIL reset_pattern: got %b required %b", {en, fl}, 8'b00000_111); end
        checks++; if ({err, stall_count, flush_count} !== 7'd0) begin errors++; $display("FAIL reset_regs: got %b required 0", {err, stall_count, flush_count}); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        checks++; if ({en, fl} !== 8'b00000_111) begin errors++; $display("FAIL init_cycle0: got %b required %b", {en, fl}, 8'b00000_111); end
        next_cycle();
        checks++; if ({en, fl} !== 8'b11111_000) begin errors++; $display("FAIL run_cycle1: got %b required %b", {en, fl}, 8'b11111_000); end
    endtask

    task automatic test_forward();
        rd_M = 6'd5; reg_write_M = 1'b1; rd_W = 6'd5; reg_write_W = 1'b1; r1_E = 6'd5; r2_E = 6'd0;
        #1;
        checks++; if ({fwd0, fwd1} !== 4'b10_00) begin errors++; $display("FAIL fwd_mem_priority: got %b required %b", {fwd0, fwd1}, 4'b10_00); end
        rd_M = 6'd7; rd_W = 6'd0;
        #1;
        checks++; if ({fwd0, fwd1} !== 4'b00_00) begin errors++; $display("FAIL fwd_zero_wb: got %b required %b", {fwd0, fwd1}, 4'b00_00); end
        rd_M = 6'd0; rd_W = 6'd9; r1_E = 6'd0; r2_E = 6'd9;
        #1;
        checks++; if ({fwd0, fwd1} !== 4'b00_01) begin errors++; $display("FAIL fwd_zero_mem_wb: got %b required %b", {fwd0, fwd1}, 4'b00_01); end
        rd_M = 6'd9; reg_write_M = 1'b0;
        #1;
        checks++; if ({fwd0, fwd1} !== 4'b00_01) begin errors++; $display("FAIL fwd_mem_nowrite: got %b required %b", {fwd0, fwd1}, 4'b00_01); end
        idle_inputs();
    endtask

    task automatic test_load_use();
        clear_perf();
        checks++; if (stall_count !== 3'd0) begin errors++; $display("FAIL lu_clear: got %0d required 0", stall_count); end
        mem_to_reg_E = 1'b1; rd_E = 6'd3; r2_D = 6'd3;
        #1;
        checks++; if ({en, fl} !== 8'b00111_010) begin errors++; $display("FAIL lu_pattern: got %b required %b", {en, fl}, 8'b00111_010); end
        next_cycle();
        checks++; if (stall_count !== 3'd1) begin errors++; $display("FAIL lu_count1: got %0d required 1", stall_count); end
        next_cycle();
        checks++; if (stall_count !== 3'd2) begin errors++; $display("FAIL lu_count2: got %0d required 2", stall_count); end
        rd_E = 6'd0; r1_D = 6'd0; r2_D = 6'd0;
        #1;
        checks++; if ({en, fl} !== 8'b11111_000) begin errors++; $display("FAIL lu_zero_reg: got %b required %b", {en, fl}, 8'b11111_000); end
        idle_inputs();
    endtask

    task automatic test_branch();
        clear_perf();
        PC_source_E = 1'b1;
        #1;
        checks++; if ({en, fl} !== 8'b11111_110) begin errors++; $display("FAIL br_pattern: got %b required %b", {en, fl}, 8'b11111_110); end
        next_cycle();
        next_cycle();
        checks++; if (flush_count !== 3'd2) begin errors++; $display("FAIL br_count: got %0d required 2", flush_count); end
        mem_transaction = 1'b1;
        #1;
        checks++; if ({en, fl} !== 8'b00000_000) begin errors++; $display("FAIL br_stall_wins: got %b required %b", {en, fl}, 8'b00000_000); end
        next_cycle();
        checks++; if (flush_count !== 3'd2) begin errors++; $display("FAIL br_stall_count: got %0d required 2", flush_count); end
        mem_transaction = 1'b0;
        #1;
        checks++; if ({en, fl} !== 8'b11111_110) begin errors++; $display("FAIL br_reeval: got %b required %b", {en, fl}, 8'b11111_110); end
        PC_source_E = 1'b0; instruction_ready = 1'b0;
        #1;
        checks++; if ({en, fl} !== 8'b01111_100) begin errors++; $display("FAIL ifetch_wait: got %b required %b", {en, fl}, 8'b01111_100); end
        idle_inputs();
    endtask

    task automatic test_timeout();
        next_cycle();
        mem_transaction = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (err !== 1'b0) begin errors++; $display("FAIL to_early_c%0d: got %b required 0", k, err); end
            next_cycle();
        end
        checks++; if ({en, fl, err} !== 9'b00000_001_1) begin errors++; $display("FAIL to_error: got %b required %b", {en, fl, err}, 9'b00000_001_1); end
        next_cycle();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b required 1", err); end
        clear_error = 1'b1; mem_transaction = 1'b0;
        next_cycle();
        checks++; if ({en, fl, err} !== 9'b00000_111_0) begin errors++; $display("FAIL to_clear_init: got %b required %b", {en, fl, err}, 9'b00000_111_0); end
        clear_error = 1'b0;
        next_cycle();
        checks++; if ({en, fl} !== 8'b11111_000) begin errors++; $display("FAIL to_clear_run: got %b required %b", {en, fl}, 8'b11111_000); end
        mem_transaction = 1'b1;
        repeat (3) next_cycle();
        data_ready = 1'b1;
        next_cycle();
        data_ready = 1'b0;
        repeat (3) next_cycle();
        checks++; if ({en, err} !== 6'b00000_0) begin errors++; $display("FAIL to_released: got %b required %b", {en, err}, 6'b00000_0); end
        mem_transaction = 1'b0; clear_error = 1'b1;
        next_cycle();
        checks++; if ({en, fl, err} !== 9'b11111_000_0) begin errors++; $display("FAIL clr_outside_err: got %b required %b", {en, fl, err}, 9'b11111_000_0); end
        idle_inputs();
    endtask

    task automatic test_saturate();
        clear_perf();
        instruction_ready = 1'b0;
        repeat (9) next_cycle();
        checks++; if (stall_count !== 3'd7) begin errors++; $display("FAIL sat_stall: got %0d required 7", stall_count); end
        perf_clear = 1'b1;
        next_cycle();
        checks++; if (stall_count !== 3'd0) begin errors++; $display("FAIL sat_clear_prio: got %0d required 0", stall_count); end
        perf_clear = 1'b0;
        next_cycle();
        checks++; if (stall_count !== 3'd1) begin errors++; $display("FAIL sat_restart: got %0d required 1", stall_count); end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        mem_transaction = 1'b1;
        repeat (4) next_cycle();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL ar_enter_err: got %b required 1", err); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({en, fl, err} !== 9'b00000_111_0) begin errors++; $display("FAIL ar_pattern: got %b required %b", {en, fl, err}, 9'b00000_111_0); end
        checks++; if ({stall_count, flush_count} !== 6'd0) begin errors++; $display("FAIL ar_counters: got %b required 0", {stall_count, flush_count}); end
        idle_inputs();
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        checks++; if ({en, fl} !== 8'b11111_000) begin errors++; $display("FAIL ar_recover: got %b required %b", {en, fl}, 8'b11111_000); end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_branch();
        test_timeout();
        test_saturate();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
